// File: rtl/koa_ctrl_pkg.sv
// Shared definitions for the KOA multiplier controller: FSM encoding,
// requester ID width and the counter-width helper.
// Build option: define KOA_CTRL_RR_EN for round-robin arbitration
// (fixed priority to requester 0 otherwise).
package koa_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } koa_state_e;

    localparam int KOA_ID_W = 1;

    // Width needed to hold values 0..lat for the WAIT down-counter.
    function automatic int koa_cnt_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/koa_rr_arbiter.sv
// Two-input grant logic for the KOA controller.
// Build option: KOA_CTRL_RR_EN selects round-robin with a one-bit pointer;
// without it, requester 0 wins every tie and no pointer flop exists.
module koa_rr_arbiter
    import koa_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                valid0,
    input  logic                valid1,
    input  logic                advance,
    output logic                gnt0,
    output logic                gnt1,
    output logic [KOA_ID_W-1:0] gnt_id
);

`ifdef KOA_CTRL_RR_EN
    // Pointer names the requester favoured on the next tie; it moves to the
    // other requester whenever a grant is taken.
    logic ptr_q;

    // Pointer update on every accepted grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else if (advance) begin
            ptr_q <= ~gnt1;
        end
    end

    // Tie resolved by the pointer, single requester granted directly.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (valid0 && valid1) begin
            gnt0 = ~ptr_q;
            gnt1 = ptr_q;
        end else begin
            gnt0 = valid0;
            gnt1 = valid1;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, advance};

    // Fixed priority: requester 0 always wins a tie.
    always_comb begin
        gnt0 = valid0;
        gnt1 = valid1 & ~valid0;
    end
`endif

    assign gnt_id = KOA_ID_W'(gnt1);

endmodule

// File: rtl/koa_approx_mult_ctrl.sv
// Sequencer and 2-way arbiter in front of one Simple_KOA_STAGE_2_approx.
// Accepts one operand pair at a time, holds it on mult_a_o/mult_b_o, pulses
// mult_load_o once the stage result has settled, then returns the product
// tagged with the requester ID.
// Build option: KOA_CTRL_RR_EN (round-robin tie-break, see koa_rr_arbiter).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req*_ready_o is combinational and only ever high in IDLE for the
// granted requester; rsp_valid_o holds with stable id/data until rsp_ready_i.
module koa_approx_mult_ctrl
    import koa_ctrl_pkg::*;
#(
    parameter int SW  = 24,
    parameter int LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid_i,
    output logic                req0_ready_o,
    input  logic [SW-1:0]       req0_a_i,
    input  logic [SW-1:0]       req0_b_i,
    input  logic                req1_valid_i,
    output logic                req1_ready_o,
    input  logic [SW-1:0]       req1_a_i,
    input  logic [SW-1:0]       req1_b_i,
    output logic [SW-1:0]       mult_a_o,
    output logic [SW-1:0]       mult_b_o,
    output logic                mult_load_o,
    input  logic [2*SW-1:0]     mult_result_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [KOA_ID_W-1:0] rsp_id_o,
    output logic [2*SW-1:0]     rsp_data_o,
    output logic                busy_o
);

    localparam int               CNT_W    = koa_cnt_w(LAT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    koa_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                idle_ok;
    logic                gnt0;
    logic                gnt1;
    logic                take;
    logic [KOA_ID_W-1:0] gnt_id;

    // Grants are only offered in IDLE and never while reset is asserted.
    assign idle_ok = (state_q == IDLE) && rst;

    koa_rr_arbiter u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid0  (req0_valid_i & idle_ok),
        .valid1  (req1_valid_i & idle_ok),
        .advance (take),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .gnt_id  (gnt_id)
    );

    assign take         = gnt0 | gnt1;
    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign busy_o       = (state_q != IDLE);

    // Main sequencer: accept, wait LAT cycles, capture, hold response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mult_a_o    <= '0;
            mult_b_o    <= '0;
            mult_load_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_data_o  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        mult_a_o    <= gnt1 ? req1_a_i : req0_a_i;
                        mult_b_o    <= gnt1 ? req1_b_i : req0_b_i;
                        rsp_id_o    <= gnt_id;
                        cnt_q       <= CNT_INIT;
                        // With LAT=1 the single WAIT cycle is also the load cycle.
                        mult_load_o <= (LAT == 1);
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        mult_load_o <= 1'b0;
                        state_q     <= CAPT;
                    end else begin
                        cnt_q       <= cnt_q - CNT_ONE;
                        mult_load_o <= (cnt_q == CNT_ONE);
                    end
                end
                CAPT: begin
                    rsp_data_o  <= mult_result_i;
                    rsp_valid_o <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_koa_approx_mult_ctrl.sv
// Bench for koa_approx_mult_ctrl with a behavioural model of the KOA stage
// (one pipeline register plus a load-enabled final register, LAT=2).
// Define KOA_CTRL_RR_EN to build and check the round-robin variant.
module tb_koa_approx_mult_ctrl;

    localparam int SW  = 24;
    localparam int LAT = 2;
    localparam int RW  = 2 * SW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid = 1'b0;
    logic          req1_valid = 1'b0;
    logic [SW-1:0] req0_a = '0;
    logic [SW-1:0] req0_b = '0;
    logic [SW-1:0] req1_a = '0;
    logic [SW-1:0] req1_b = '0;
    logic          rsp_ready = 1'b0;
    logic          req0_ready;
    logic          req1_ready;
    logic [SW-1:0] mult_a;
    logic [SW-1:0] mult_b;
    logic          mult_load;
    logic [RW-1:0] mult_result;
    logic          rsp_valid;
    logic          rsp_id;
    logic [RW-1:0] rsp_data;
    logic          busy;

    logic [RW:0]   exp_q[$];
    int            n_pass = 0;
    int            n_total = 0;
    int unsigned   cyc_cnt = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want summary");
        $fatal(1);
    end

    // ---------------- stage model ----------------
    logic [RW-1:0] stage_pipe;
    logic [RW-1:0] stage_final;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_pipe  <= '0;
            stage_final <= '0;
        end else begin
            stage_pipe <= RW'(mult_a) * RW'(mult_b);
            if (mult_load) stage_final <= stage_pipe;
        end
    end

    assign mult_result = stage_final;

    koa_approx_mult_ctrl #(.SW(SW), .LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_valid_i  (req0_valid),
        .req0_ready_o  (req0_ready),
        .req0_a_i      (req0_a),
        .req0_b_i      (req0_b),
        .req1_valid_i  (req1_valid),
        .req1_ready_o  (req1_ready),
        .req1_a_i      (req1_a),
        .req1_b_i      (req1_b),
        .mult_a_o      (mult_a),
        .mult_b_o      (mult_b),
        .mult_load_o   (mult_load),
        .mult_result_i (mult_result),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_id_o      (rsp_id),
        .rsp_data_o    (rsp_data),
        .busy_o        (busy)
    );

    // ---------------- driver tasks ----------------
    task automatic drive_req(input int id, input logic v, input logic [SW-1:0] a, input logic [SW-1:0] b);
        if (id == 0) begin
            req0_valid = v; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b;
        end
    endtask

    // Returns the requester whose ready is seen (-1 on timeout); the
    // accepting edge is the next rising edge.
    task automatic wait_grant(input int limit, output int gid, output int cyc);
        cyc = 0;
        gid = -1;
        #1;
        while (!(req0_ready || req1_ready) && cyc < limit) begin
            @(negedge clk); #1;
            cyc++;
        end
        if (req0_ready) gid = 0;
        else if (req1_ready) gid = 1;
    endtask

    // Counts falling edges (and load pulses) until rsp_valid is seen.
    task automatic wait_rsp(input int limit, output int cyc, output int loads);
        cyc = 0;
        loads = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (mult_load) loads++;
        end while (!rsp_valid && cyc < limit);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [101:0] outs;
        rst = 1'b0;
        drive_req(0, 1'b1, 24'h123456, 24'h000777);
        drive_req(1, 1'b1, 24'h00abcd, 24'h000011);
        repeat (3) @(negedge clk);
        #1;
        outs = {mult_a, mult_b, rsp_data, rsp_id, mult_load, rsp_valid, busy, req0_ready, req1_ready};
        n_total++;
        if (outs !== '0) $display("FAIL reset_outputs: got %0h want 0", outs); else n_pass++;
        n_total++;
        if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready}); else n_pass++;
        drive_req(0, 1'b0, '0, '0);
        drive_req(1, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_single();
        int gid, cyc, loads;
        logic [RW:0] e;
        @(negedge clk);
        drive_req(0, 1'b1, 24'd3, 24'd5);
        wait_grant(20, gid, cyc);
        n_total++;
        if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready}); else n_pass++;
        exp_q.push_back({1'b0, 48'd15});
        @(posedge clk); #1;
        drive_req(0, 1'b0, '0, '0);
        wait_rsp(20, cyc, loads);
        n_total++;
        if (rsp_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", rsp_valid); else n_pass++;
        n_total++;
        if (cyc != LAT + 2) $display("FAIL single_latency: got %0d want %0d", cyc, LAT + 2); else n_pass++;
        n_total++;
        if (loads != 1) $display("FAIL single_load_pulses: got %0d want 1", loads); else n_pass++;
        n_total++;
        if (rsp_id !== 1'b0) $display("FAIL single_id: got %b want 0", rsp_id); else n_pass++;
        n_total++;
        if (exp_q.size() == 0) $display("FAIL single_sb: got %0h want none queued", rsp_data);
        else begin
            e = exp_q.pop_front();
            if ({rsp_id, rsp_data} !== e) $display("FAIL single_sb: got %0h want %0h", {rsp_id, rsp_data}, e); else n_pass++;
        end
        take_rsp();
        loads = 0;
        repeat (3) begin
            @(negedge clk);
            if (mult_load) loads++;
        end
        n_total++;
        if ({busy, rsp_valid, loads != 0} !== 3'b000) $display("FAIL single_after: got busy=%b valid=%b extra_loads=%0d want 0/0/0", busy, rsp_valid, loads); else n_pass++;
    endtask

    task automatic test_tie();
        int gid, cyc, loads, exp_g, pend;
        logic [SW-1:0] a0, b0, a1, b1;
        logic [RW:0] e;
        a0 = SW'($urandom_range(1, 4095)); b0 = SW'($urandom_range(1, 4095));
        a1 = SW'($urandom_range(4096, 65535)); b1 = SW'($urandom_range(4096, 65535));
        exp_g = 0;
        @(negedge clk);
        drive_req(0, 1'b1, a0, b0);
        drive_req(1, 1'b1, a1, b1);
        for (int k = 0; k < 4; k++) begin
            wait_grant(20, gid, cyc);
`ifdef KOA_CTRL_RR_EN
            exp_g = k % 2;
`else
            exp_g = 0;
`endif
            n_total++;
            if (gid != exp_g || (req0_ready && req1_ready)) $display("FAIL tie_grant_%0d: got %0d want %0d", k, gid, exp_g); else n_pass++;
            exp_q.push_back({1'(exp_g), (exp_g == 0) ? RW'(a0) * RW'(b0) : RW'(a1) * RW'(b1)});
            @(posedge clk); #1;
            if (exp_g == 0) begin
                a0 = SW'($urandom); b0 = SW'($urandom);
                drive_req(0, (k != 3), a0, b0);
            end else begin
                a1 = SW'($urandom); b1 = SW'($urandom);
                drive_req(1, (k != 3), a1, b1);
            end
            wait_rsp(20, cyc, loads);
            n_total++;
            if (!rsp_valid || exp_q.size() == 0) $display("FAIL tie_rsp_%0d: got valid=%b want 1", k, rsp_valid);
            else begin
                e = exp_q.pop_front();
                if ({rsp_id, rsp_data} !== e) $display("FAIL tie_rsp_%0d: got %0h want %0h", k, {rsp_id, rsp_data}, e); else n_pass++;
            end
            take_rsp();
        end
        // The requester that never dropped valid is served next.
        pend = 1 - exp_g;
        wait_grant(20, gid, cyc);
        n_total++;
        if (gid != pend) $display("FAIL tie_pending_grant: got %0d want %0d", gid, pend); else n_pass++;
        exp_q.push_back({1'(pend), (pend == 0) ? RW'(a0) * RW'(b0) : RW'(a1) * RW'(b1)});
        @(posedge clk); #1;
        drive_req(0, 1'b0, '0, '0);
        drive_req(1, 1'b0, '0, '0);
        wait_rsp(20, cyc, loads);
        n_total++;
        if (!rsp_valid || exp_q.size() == 0) $display("FAIL tie_pending_rsp: got valid=%b want 1", rsp_valid);
        else begin
            e = exp_q.pop_front();
            if ({rsp_id, rsp_data} !== e) $display("FAIL tie_pending_rsp: got %0h want %0h", {rsp_id, rsp_data}, e); else n_pass++;
        end
        take_rsp();
    endtask

    task automatic test_backpressure();
        int gid, cyc, loads, bad_rsp, bad_rdy, bad_busy;
        logic [SW-1:0] a, b, c, d;
        logic [RW:0] e;
        a = SW'($urandom); b = SW'($urandom);
        c = SW'($urandom); d = SW'($urandom);
        @(negedge clk);
        drive_req(0, 1'b1, a, b);
        wait_grant(20, gid, cyc);
        exp_q.push_back({1'b0, RW'(a) * RW'(b)});
        @(posedge clk); #1;
        drive_req(0, 1'b0, '0, '0);
        wait_rsp(20, cyc, loads);
        n_total++;
        if (rsp_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", rsp_valid); else n_pass++;
        drive_req(1, 1'b1, c, d);
        bad_rsp = 0; bad_rdy = 0; bad_busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0 || {rsp_valid, rsp_id, rsp_data} !== {1'b1, exp_q[0]}) bad_rsp++;
            if (req0_ready || req1_ready) bad_rdy++;
            if (busy !== 1'b1) bad_busy++;
        end
        n_total++;
        if (bad_rsp != 0) $display("FAIL bp_rsp_stable: got %0d bad cycles want 0", bad_rsp); else n_pass++;
        n_total++;
        if (bad_rdy != 0) $display("FAIL bp_ready_low: got %0d bad cycles want 0", bad_rdy); else n_pass++;
        n_total++;
        if (bad_busy != 0) $display("FAIL bp_busy: got %0d bad cycles want 0", bad_busy); else n_pass++;
        n_total++;
        if (exp_q.size() == 0) $display("FAIL bp_sb: got %0h want none queued", rsp_data);
        else begin
            e = exp_q.pop_front();
            if ({rsp_id, rsp_data} !== e) $display("FAIL bp_sb: got %0h want %0h", {rsp_id, rsp_data}, e); else n_pass++;
        end
        take_rsp();
        wait_grant(20, gid, cyc);
        n_total++;
        if (gid != 1) $display("FAIL bp_next_grant: got %0d want 1", gid); else n_pass++;
        exp_q.push_back({1'b1, RW'(c) * RW'(d)});
        @(posedge clk); #1;
        drive_req(1, 1'b0, '0, '0);
        wait_rsp(20, cyc, loads);
        n_total++;
        if (!rsp_valid || exp_q.size() == 0) $display("FAIL bp_next_rsp: got valid=%b want 1", rsp_valid);
        else begin
            e = exp_q.pop_front();
            if ({rsp_id, rsp_data} !== e) $display("FAIL bp_next_rsp: got %0h want %0h", {rsp_id, rsp_data}, e); else n_pass++;
        end
        take_rsp();
    endtask

    task automatic test_reset_mid_op();
        int gid, cyc, loads, spurious;
        logic [SW-1:0] a, b;
        logic [RW:0] e;
        logic [101:0] outs;
        a = SW'($urandom); b = SW'($urandom);
        @(negedge clk);
        drive_req(0, 1'b1, a, b);
        wait_grant(20, gid, cyc);
        @(posedge clk); #1;
        drive_req(0, 1'b0, '0, '0);
        @(negedge clk); #1;
        n_total++;
        if (busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b want 1", busy); else n_pass++;
        rst = 1'b0;
        #1;
        outs = {mult_a, mult_b, rsp_data, rsp_id, mult_load, rsp_valid, busy, req0_ready, req1_ready};
        n_total++;
        if (outs !== '0) $display("FAIL rst_mid_async: got %0h want 0", outs); else n_pass++;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        spurious = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || busy) spurious++;
        end
        n_total++;
        if (spurious != 0) $display("FAIL rst_mid_spurious: got %0d cycles want 0", spurious); else n_pass++;
        a = SW'($urandom); b = SW'($urandom);
        drive_req(1, 1'b1, a, b);
        wait_grant(20, gid, cyc);
        exp_q.push_back({1'b1, RW'(a) * RW'(b)});
        @(posedge clk); #1;
        drive_req(1, 1'b0, '0, '0);
        wait_rsp(20, cyc, loads);
        n_total++;
        if (!rsp_valid || cyc != LAT + 2 || exp_q.size() == 0) $display("FAIL rst_mid_recover: got valid=%b latency=%0d want 1/%0d", rsp_valid, cyc, LAT + 2);
        else begin
            e = exp_q.pop_front();
            if ({rsp_id, rsp_data} !== e) $display("FAIL rst_mid_recover: got %0h want %0h", {rsp_id, rsp_data}, e); else n_pass++;
        end
        take_rsp();
    endtask

    task automatic test_operand_hold();
        int gid, cyc, loads, hold_bad;
        logic [SW-1:0] x, y, z;
        logic [RW:0] e;
        x = SW'($urandom); y = SW'($urandom); z = ~x;
        @(negedge clk);
        drive_req(0, 1'b1, x, y);
        wait_grant(20, gid, cyc);
        exp_q.push_back({1'b0, RW'(x) * RW'(y)});
        @(posedge clk); #1;
        drive_req(0, 1'b0, ~x, ~y);
        hold_bad = 0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (mult_a !== x || mult_b !== y) hold_bad++;
        end while (!rsp_valid && cyc < 20);
        n_total++;
        if (!rsp_valid || exp_q.size() == 0) $display("FAIL hold_rsp: got valid=%b want 1", rsp_valid);
        else begin
            e = exp_q.pop_front();
            if ({rsp_id, rsp_data} !== e) $display("FAIL hold_rsp: got %0h want %0h", {rsp_id, rsp_data}, e); else n_pass++;
        end
        take_rsp();
        repeat (3) begin
            @(negedge clk);
            if (mult_a !== x || mult_b !== y) hold_bad++;
        end
        n_total++;
        if (hold_bad != 0) $display("FAIL hold_operands: got %0d changed cycles want 0", hold_bad); else n_pass++;
        drive_req(0, 1'b1, z, y);
        wait_grant(20, gid, cyc);
        exp_q.push_back({1'b0, RW'(z) * RW'(y)});
        @(posedge clk); #1;
        drive_req(0, 1'b0, '0, '0);
        n_total++;
        if (mult_a !== z) $display("FAIL hold_next_accept: got %0h want %0h", mult_a, z); else n_pass++;
        wait_rsp(20, cyc, loads);
        n_total++;
        if (!rsp_valid || exp_q.size() == 0) $display("FAIL hold_next_rsp: got valid=%b want 1", rsp_valid);
        else begin
            e = exp_q.pop_front();
            if ({rsp_id, rsp_data} !== e) $display("FAIL hold_next_rsp: got %0h want %0h", {rsp_id, rsp_data}, e); else n_pass++;
        end
        take_rsp();
    endtask

    task automatic test_max_values();
        int gid, cyc;
        logic [RW-1:0] capt;
        logic [RW:0] e;
        capt = '0;
        @(negedge clk);
        drive_req(0, 1'b1, 24'hFFFFFF, 24'hFFFFFF);
        wait_grant(20, gid, cyc);
        exp_q.push_back({1'b0, 48'hFFFFFE000001});
        @(posedge clk); #1;
        drive_req(0, 1'b0, '0, '0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == LAT + 1) capt = mult_result;
        end while (!rsp_valid && cyc < 20);
        n_total++;
        if (rsp_data !== capt) $display("FAIL max_vs_stage: got %0h want %0h", rsp_data, capt); else n_pass++;
        n_total++;
        if (!rsp_valid || exp_q.size() == 0) $display("FAIL max_rsp: got valid=%b want 1", rsp_valid);
        else begin
            e = exp_q.pop_front();
            if ({rsp_id, rsp_data} !== e) $display("FAIL max_rsp: got %0h want %0h", {rsp_id, rsp_data}, e); else n_pass++;
        end
        take_rsp();
    endtask

    task automatic test_back_to_back();
        int gid, cyc, loads, cur, id_bad, per_bad;
        int unsigned t_prev, t_now;
        logic [SW-1:0] a, b;
        logic [RW:0] e;
        id_bad = 0; per_bad = 0; t_prev = 0;
        rsp_ready = 1'b1;
        cur = $urandom_range(0, 1);
        a = SW'($urandom); b = SW'($urandom);
        @(negedge clk);
        drive_req(cur, 1'b1, a, b);
        for (int k = 0; k < 6; k++) begin
            wait_grant(20, gid, cyc);
            t_now = cyc_cnt;
            if (gid != cur) id_bad++;
            if (k > 0 && (t_now - t_prev) != LAT + 3) per_bad++;
            t_prev = t_now;
            exp_q.push_back({1'(cur), RW'(a) * RW'(b)});
            @(posedge clk); #1;
            drive_req(cur, 1'b0, '0, '0);
            if (k < 5) begin
                cur = $urandom_range(0, 1);
                a = SW'($urandom); b = SW'($urandom);
                drive_req(cur, 1'b1, a, b);
            end
            wait_rsp(20, cyc, loads);
            n_total++;
            if (!rsp_valid || exp_q.size() == 0) $display("FAIL b2b_rsp_%0d: got valid=%b want 1", k, rsp_valid);
            else begin
                e = exp_q.pop_front();
                if ({rsp_id, rsp_data} !== e) $display("FAIL b2b_rsp_%0d: got %0h want %0h", k, {rsp_id, rsp_data}, e); else n_pass++;
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_total++;
        if (id_bad != 0) $display("FAIL b2b_grant_id: got %0d wrong grants want 0", id_bad); else n_pass++;
        n_total++;
        if (per_bad != 0) $display("FAIL b2b_throughput: got %0d off-period accepts want 0", per_bad); else n_pass++;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL b2b_queue_empty: got %0d left want 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_reset_mid_op();
        test_operand_hold();
        test_max_values();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
